// File: rtl/multicycle_ctrl_if.sv
// Handshake bundle between the multicycle controller (slave side) and the core/memories (master side).
// The retired-instruction count is present only when RETIRE_COUNT_EN is defined.
interface multicycle_ctrl_if;
  logic       is_illegal;
  logic       gp_we_dec;
  logic       dm_we_dec;
  logic       is_load;
  logic       im_ack;
  logic       dm_ack;
  logic       im_req;
  logic       ir_we;
  logic       dm_req;
  logic       dm_we;
  logic       gp_we;
  logic       pc_we;
  logic       halted;
  logic [2:0] state;
`ifdef RETIRE_COUNT_EN
  logic [31:0] retired;

  modport slave (
    input  is_illegal, gp_we_dec, dm_we_dec, is_load, im_ack, dm_ack,
    output im_req, ir_we, dm_req, dm_we, gp_we, pc_we, halted, state, retired
  );
  modport master (
    output is_illegal, gp_we_dec, dm_we_dec, is_load, im_ack, dm_ack,
    input  im_req, ir_we, dm_req, dm_we, gp_we, pc_we, halted, state, retired
  );
`else
  modport slave (
    input  is_illegal, gp_we_dec, dm_we_dec, is_load, im_ack, dm_ack,
    output im_req, ir_we, dm_req, dm_we, gp_we, pc_we, halted, state
  );
  modport master (
    output is_illegal, gp_we_dec, dm_we_dec, is_load, im_ack, dm_ack,
    input  im_req, ir_we, dm_req, dm_we, gp_we, pc_we, halted, state
  );
`endif
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle instruction sequencer: FETCH -> DECODE -> EXEC -> (MEM) -> (WB), with HALT on illegal opcodes.
// Define RETIRE_COUNT_EN to add a 32-bit wrapping count of retired instructions (pc_we pulses).
module multicycle_ctrl (
  input  logic             clk,
  input  logic             reset,
  multicycle_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  state_t cur;
  logic   fetch_req;
  logic   mem_req;
  logic   wb_stb;
  logic   halt_flag;
  logic   exec_retire;

  // Request/strobe flags are registered alongside the state so they carry no ack-to-output path;
  // only ir_we and the store-completion pc_we are allowed to follow the acks combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur       <= FETCH;
      fetch_req <= 1'b0;
      mem_req   <= 1'b0;
      wb_stb    <= 1'b0;
      halt_flag <= 1'b0;
    end else begin
      case (cur)
        FETCH: begin
          if (fetch_req && bus.im_ack) begin
            cur       <= DECODE;
            fetch_req <= 1'b0;
          end else begin
            fetch_req <= 1'b1;
          end
        end
        DECODE: begin
          if (bus.is_illegal) begin
            cur       <= HALT;
            halt_flag <= 1'b1;
          end else begin
            cur <= EXEC;
          end
        end
        EXEC: begin
          if (bus.is_load || bus.dm_we_dec) begin
            cur     <= MEM;
            mem_req <= 1'b1;
          end else if (bus.gp_we_dec) begin
            cur    <= WB;
            wb_stb <= 1'b1;
          end else begin
            cur       <= FETCH;
            fetch_req <= 1'b1;
          end
        end
        MEM: begin
          if (bus.dm_ack) begin
            mem_req <= 1'b0;
            if (bus.dm_we_dec) begin
              cur       <= FETCH;
              fetch_req <= 1'b1;
            end else begin
              cur    <= WB;
              wb_stb <= 1'b1;
            end
          end
        end
        WB: begin
          cur       <= FETCH;
          wb_stb    <= 1'b0;
          fetch_req <= 1'b1;
        end
        HALT: begin
          cur <= HALT;
        end
        default: begin
          cur       <= FETCH;
          fetch_req <= 1'b1;
          mem_req   <= 1'b0;
          wb_stb    <= 1'b0;
          halt_flag <= 1'b0;
        end
      endcase
    end
  end

  // Branch/jump/nop retires straight out of EXEC.
  assign exec_retire = (cur == EXEC) && !bus.is_load && !bus.dm_we_dec && !bus.gp_we_dec;

  assign bus.im_req = fetch_req;
  assign bus.ir_we  = fetch_req & bus.im_ack;
  assign bus.dm_req = mem_req;
  assign bus.dm_we  = mem_req & bus.dm_we_dec;
  assign bus.gp_we  = wb_stb;
  assign bus.pc_we  = exec_retire | wb_stb | (mem_req & bus.dm_ack & bus.dm_we_dec);
  assign bus.halted = halt_flag;
  assign bus.state  = cur;

`ifdef RETIRE_COUNT_EN
  logic [31:0] retired_cnt;

  always_ff @(posedge clk) begin
    if (reset)
      retired_cnt <= 32'd0;
    else if (bus.pc_we)
      retired_cnt <= retired_cnt + 32'd1;
  end

  assign bus.retired = retired_cnt;
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction expected cycle traces built from the
// instruction class and ack delays, compared cycle by cycle against the controller outputs.
module tb_multicycle_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus ();
  multicycle_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  localparam int K_ALU = 0, K_LW = 1, K_SW = 2, K_BR = 3, K_ILL = 4;

  typedef struct {
    logic       ia;
    logic       da;
    logic [9:0] ex;
  } cyc_t;

  cyc_t tr[$];

  // {state, im_req, ir_we, dm_req, dm_we, gp_we, pc_we, halted}
  function automatic logic [9:0] pk(input int st, input bit ireq, input bit irw, input bit dreq,
                                    input bit dwe, input bit gwe, input bit pwe, input bit hlt);
    return {3'(st), ireq, irw, dreq, dwe, gwe, pwe, hlt};
  endfunction

  function automatic cyc_t mk(input bit ia, input bit da, input logic [9:0] ex);
    cyc_t c;
    c.ia = ia;
    c.da = da;
    c.ex = ex;
    return c;
  endfunction

  function automatic logic [9:0] obs();
    return {bus.state, bus.im_req, bus.ir_we, bus.dm_req, bus.dm_we, bus.gp_we, bus.pc_we, bus.halted};
  endfunction

  function automatic bit rb();
    return 1'($urandom);
  endfunction

  // Expected behaviour of one instruction, phase by phase.
  task automatic build_trace(input int kind, input int imd, input int dmd, input int nhalt);
    bit store;
    store = (kind == K_SW);
    tr.delete();
    for (int i = 0; i < imd; i++) tr.push_back(mk(1'b0, rb(), pk(0, 1, 0, 0, 0, 0, 0, 0)));
    tr.push_back(mk(1'b1, rb(), pk(0, 1, 1, 0, 0, 0, 0, 0)));
    tr.push_back(mk(rb(), rb(), pk(1, 0, 0, 0, 0, 0, 0, 0)));
    if (kind == K_ILL) begin
      for (int i = 0; i < nhalt; i++) tr.push_back(mk(rb(), rb(), pk(5, 0, 0, 0, 0, 0, 0, 1)));
      return;
    end
    tr.push_back(mk(rb(), rb(), pk(2, 0, 0, 0, 0, 0, (kind == K_BR), 0)));
    if (kind == K_LW || kind == K_SW) begin
      for (int i = 0; i < dmd; i++) tr.push_back(mk(rb(), 1'b0, pk(3, 0, 0, 1, store, 0, 0, 0)));
      tr.push_back(mk(rb(), 1'b1, pk(3, 0, 0, 1, store, 0, store, 0)));
    end
    if (kind == K_ALU || kind == K_LW) tr.push_back(mk(rb(), rb(), pk(4, 0, 0, 0, 0, 1, 1, 0)));
  endtask

  task automatic run_instr(input int kind, input int imd, input int dmd, input int nhalt, input int stop);
    build_trace(kind, imd, dmd, nhalt);
    for (int i = 0; i < tr.size() && (stop < 0 || i < stop); i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        bus.is_illegal = (kind == K_ILL);
        bus.is_load    = (kind == K_LW);
        bus.dm_we_dec  = (kind == K_SW);
        case (kind)
          K_ALU, K_LW: bus.gp_we_dec = 1'b1;
          K_SW, K_ILL: bus.gp_we_dec = rb();
          default:     bus.gp_we_dec = 1'b0;
        endcase
        if (kind == K_ILL) begin
          bus.is_load   = rb();
          bus.dm_we_dec = rb();
        end
      end
      bus.im_ack = tr[i].ia;
      bus.dm_ack = tr[i].da;
      @(negedge clk);
      n_checks++;
      if (obs() !== tr[i].ex) begin
        n_fail++;
        $display("FAIL instr kind=%0d cycle=%0d: got state/flags=%b_%b want %b_%b",
                 kind, i, obs()[9:7], obs()[6:0], tr[i].ex[9:7], tr[i].ex[6:0]);
      end
    end
  endtask

  task automatic test_reset(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk); #1;
      reset = 1'b1;
      bus.im_ack = rb(); bus.dm_ack = rb();
      bus.gp_we_dec = rb(); bus.dm_we_dec = rb(); bus.is_load = rb(); bus.is_illegal = rb();
      @(negedge clk);
      if (i > 0) begin
        n_checks++;
        if (obs() !== 10'd0) begin
          n_fail++;
          $display("FAIL reset_hold cycle=%0d: got %b want 0000000000", i, obs());
        end
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
    bus.im_ack = rb(); bus.dm_ack = rb();
    @(negedge clk);
    n_checks++;
    if (obs() !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_release: got %b want 0000000000", obs());
    end
  endtask

  task automatic test_alu_zero_wait();
    run_instr(K_ALU, 0, 0, 0, -1);
  endtask

  task automatic test_load_delayed();
    run_instr(K_LW, 1, 3, 0, -1);
  endtask

  task automatic test_store_zero_wait();
    run_instr(K_SW, 0, 0, 0, -1);
  endtask

  task automatic test_branch();
    run_instr(K_BR, 0, 0, 0, -1);
    run_instr(K_BR, 2, 0, 0, -1);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 40; n++)
      run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0, -1);
  endtask

  task automatic test_halt();
    run_instr(K_ILL, int'($urandom_range(0, 2)), 0, 20, -1);
    test_reset(2);
    run_instr(K_ALU, 0, 0, 0, -1);
  endtask

  task automatic test_reset_mid_mem();
    // Stop after F, D, E and two MEM cycles with the load still outstanding.
    run_instr(K_LW, 0, 10, 0, 5);
    test_reset(2);
    run_instr(K_SW, 1, 1, 0, -1);
  endtask

`ifdef RETIRE_COUNT_EN
  task automatic test_retire_wrap();
    test_reset(2);
    force dut.retired_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.retired_cnt;
    run_instr(K_BR, 0, 0, 0, -1);
    n_checks++;
    if (bus.retired !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL retire_preload: got %h want ffffffff", bus.retired);
    end
    @(posedge clk); #1;
    bus.im_ack = 1'b0; bus.dm_ack = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.retired !== 32'd0) begin
      n_fail++;
      $display("FAIL retire_wrap: got %h want 00000000", bus.retired);
    end
  endtask
`endif

  initial begin
    bus.is_illegal = 1'b0; bus.gp_we_dec = 1'b0; bus.dm_we_dec = 1'b0; bus.is_load = 1'b0;
    bus.im_ack = 1'b0; bus.dm_ack = 1'b0;
    test_reset(3);
    test_alu_zero_wait();
    test_load_delayed();
    test_store_zero_wait();
    test_branch();
    test_back_to_back();
    test_reset_mid_mem();
    test_halt();
`ifdef RETIRE_COUNT_EN
    test_retire_wrap();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset sampled on rising clk.
REQ-003 SHALL have port is_illegal, input, 1, decoder flag for an undefined instruction.
REQ-004 SHALL have port gp_we_dec, input, 1, decoder register-write request.
REQ-005 SHALL have port dm_we_dec, input, 1, decoder store request (sw).
REQ-006 SHALL have port is_load, input, 1, instruction is lw (opcode 100011).
REQ-007 SHALL have port im_ack, input, 1, instruction memory data valid.
REQ-008 SHALL have port dm_ack, input, 1, data memory access complete.
REQ-009 SHALL have port im_req, output, 1, instruction fetch request.
REQ-010 SHALL have port ir_we, output, 1, instruction register load strobe.
REQ-011 SHALL have port dm_req, output, 1, data memory request.
REQ-012 SHALL have port dm_we, output, 1, data memory write enable.
REQ-013 SHALL have port gp_we, output, 1, register file write strobe.
REQ-014 SHALL have port pc_we, output, 1, PC update strobe.
REQ-015 SHALL have port halted, output, 1, core stopped on illegal instruction.
REQ-016 SHALL have port state, output, 3, current state encoding for debug.

Function
REQ-017 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; codes 6-7 SHALL go to FETCH next cycle.
REQ-018 FETCH: im_req=1; on im_ack, ir_we=1 in the same cycle -> DECODE; no im_ack -> stay in FETCH.
REQ-019 DECODE: is_illegal=1 -> HALT; otherwise -> EXEC; one cycle.
REQ-020 EXEC: is_load or dm_we_dec -> MEM; else gp_we_dec -> WB; else pc_we=1 -> FETCH (branch/jump/nop).
REQ-021 MEM: dm_req=1, dm_we=dm_we_dec; on dm_ack: store -> pc_we=1, FETCH; load -> WB; no dm_ack -> stay in MEM with request held steady.
REQ-022 WB: gp_we=1 and pc_we=1 for exactly one cycle -> FETCH.
REQ-023 HALT: halted=1, all strobes and requests 0; exits only by reset.
REQ-024 im_ack outside FETCH and dm_ack outside MEM SHALL be ignored.
REQ-025 An ack in the first cycle of its request SHALL be accepted (zero wait).
REQ-026 Each of ir_we, gp_we, pc_we SHALL pulse at most once per instruction.
REQ-027 Latency: ALU op 5 cycles, lw 6, sw 5, branch 4, with zero-wait acks.
REQ-028 Outputs other than ir_we and pc_we in MEM SHALL depend only on state plus decoder inputs, with no combinational path from im_ack/dm_ack except ir_we, pc_we, and the gp_we-free MEM exit.

Reset
REQ-029 reset=1 SHALL force state FETCH and all outputs 0 (im_req goes high the cycle after release).
REQ-030 reset SHALL override every state, including mid-MEM with dm_req high and HALT; the pending access is abandoned.

Configuration
REQ-031 With RETIRE_COUNT_EN defined, SHALL add output retired[31:0], reset to 0, incremented on every pc_we pulse, wrapping 0xFFFFFFFF -> 0, frozen in HALT.
REQ-032 Without RETIRE_COUNT_EN, port retired and its counter SHALL be absent.

Verification
REQ-033 Release reset, ALU op (gp_we_dec=1), zero-wait im_ack -> states 0,1,2,4,0; gp_we and pc_we high together in cycle 4.
REQ-034 lw with dm_ack delayed 3 cycles -> dm_req high 4 cycles, dm_we=0, then WB, then FETCH.
REQ-035 sw with zero-wait dm_ack -> dm_we=1 in MEM, pc_we in MEM, gp_we never asserted.
REQ-036 is_illegal=1 in DECODE -> HALT, halted=1 held 20 cycles despite acks; reset -> FETCH, halted=0.
REQ-037 reset asserted while in MEM with dm_req=1 -> next cycle state=0, all outputs 0.
REQ-038 RETIRE_COUNT_EN defined, counter preloaded 0xFFFFFFFF, one branch -> retired=0.
